// File: rtl/gaussian_window.sv
`default_nettype none
// ============================================================================
// Module      : gaussian_window
// Description : Raster pixel stream to 5x5 neighbourhood windows using four
//               line buffers and a 5x5 shift register; border windows dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module gaussian_window #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int DWIDTH     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DWIDTH-1:0]     in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [25*DWIDTH-1:0]  out_data_o,
    output logic                  out_last_o
);

    localparam int              c_xw     = $clog2(IMG_WIDTH);
    localparam int              c_yw     = $clog2(IMG_HEIGHT);
    localparam logic [c_xw-1:0] c_x_last = c_xw'(IMG_WIDTH - 1);
    localparam logic [c_yw-1:0] c_y_last = c_yw'(IMG_HEIGHT - 1);
    localparam logic [c_xw-1:0] c_x_four = c_xw'(4);
    localparam logic [c_yw-1:0] c_y_four = c_yw'(4);

    logic [c_xw-1:0]        x_q, x_d;
    logic [c_yw-1:0]        y_q, y_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [25*DWIDTH-1:0]   win_q, win_d;
    logic [DWIDTH-1:0]      lb_q [4][IMG_WIDTH];
    logic                   w_accept;

    // The window only moves on accept, so stalling the input freezes out_data.
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        win_d       = win_q;
        if (w_accept) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[(r*5+c)*DWIDTH +: DWIDTH] = win_q[(r*5+c+1)*DWIDTH +: DWIDTH];
                end
            end
            // Oldest row (y-4) sits in LB3 and lands in row 0 of the window.
            win_d[4*DWIDTH  +: DWIDTH] = lb_q[3][x_q];
            win_d[9*DWIDTH  +: DWIDTH] = lb_q[2][x_q];
            win_d[14*DWIDTH +: DWIDTH] = lb_q[1][x_q];
            win_d[19*DWIDTH +: DWIDTH] = lb_q[0][x_q];
            win_d[24*DWIDTH +: DWIDTH] = in_data_i;
            out_valid_d = (y_q >= c_y_four) && (x_q >= c_x_four);
            out_last_d  = (y_q == c_y_last) && (x_q == c_x_last);
            if (x_q == c_x_last) begin
                x_d = '0;
                y_d = (y_q == c_y_last) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            win_q       <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end

    // Line buffers are plain RAM: no reset, stale rows are masked by the y guard.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            lb_q[3][x_q] <= lb_q[2][x_q];
            lb_q[2][x_q] <= lb_q[1][x_q];
            lb_q[1][x_q] <= lb_q[0][x_q];
            lb_q[0][x_q] <= in_data_i;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = win_q;

endmodule
`default_nettype wire
